ivn_lane_extractor: RTL and testbench
=====================================

Name: ivn_lane_extractor

Overview:
- Parametrised multi-lane iterated von Neumann (Peres-style) debiasing extractor for the Markov entropy path.
- Consumes one raw bit per cycle tagged with a source lane. Runs a binary tree of pairing PEs of depth LEVELS.
- Saves and restores per-lane PE context through an internal context store on lane change.
- Emits a registered vector of extracted bits with a per-PE valid mask and a lane tag.

Parameters:
- LEVELS, 3, tree depth; NPE = 2^LEVELS - 1 PEs.
- LANES, 16, number of independent source lanes.
- LANE_W, 4, lane index width; must satisfy 2^LANE_W >= LANES.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  raw bit offered
- in_ready  out  1  raw bit accepted when in_valid && in_ready
- in_bit  in  1  raw sample
- in_lane  in  LANE_W  lane of the offered sample
- lane_flush  in  1  pulse; clears the active lane's PE context
- vn_bits  out  NPE  extracted bit per PE (registered)
- vn_mask  out  NPE  bit i set = vn_bits[i] valid this cycle
- vn_lane  out  LANE_W  lane the mask/bits belong to
- busy  out  1  context switch in progress

Behaviour:
- PE i holds {held, have}. Children of PE i: xor child 2i+1, r child 2i+2, where the index is < NPE. Only PE 0 takes external input.
- PE input event with have=0: held<=bit, have<=1, no output.
- PE input event with have=1 (pair a=held, b=bit): have<=0.
  - Mask bit set with value a iff a!=b.
  - a^b is sent as an input event to the xor child.
  - a is sent to the r child iff a==b.
- All events propagate combinationally through the tree in the accept cycle. vn_bits, vn_mask and vn_lane register on the next edge (latency 1). vn_mask=0 in cycles with no accept.
- FSM states: RUN, SAVE, LOAD.
  - RUN: in_ready = in_valid && in_lane==cur_lane && !lane_flush.
  - RUN -> SAVE when in_valid && in_lane!=cur_lane.
  - SAVE: write PE context to ctx[cur_lane]; go to LOAD.
  - LOAD: PE context <= ctx[in_lane]; cur_lane <= in_lane; go to RUN.
  - Switch penalty is 2 cycles. busy=1 in SAVE and LOAD. in_ready=0 in SAVE and LOAD.
- If in_lane changes during SAVE, LOAD uses the in_lane sampled in LOAD.
- lane_flush in RUN: active PE context cleared to zero; no accept that cycle. lane_flush outside RUN is ignored.
- Simultaneous lane_flush and lane mismatch: flush wins; the switch starts the next cycle.
- Reset, including mid-switch:
  - state=RUN, cur_lane=0.
  - All PE contexts and all LANES ctx entries zeroed.
  - vn_bits=0, vn_mask=0, vn_lane=0, busy=0, in_ready follows the RUN rule.
- Context width is 2*NPE bits per lane; the store is LANES entries.

Optional Feature:
- IVN_STATS_EN defined adds ports stat_lane (in, LANE_W) and stat_count (out, 16).
  - stat_count is the saturating count of extracted bits (popcount of vn_mask) for lane stat_lane, read combinationally.
  - The count updates one cycle after vn_mask. It saturates at 16'hFFFF.
  - Counters are cleared by reset and by lane_flush of that lane.
- IVN_STATS_EN undefined: no ports and no counters.

Decomposition:
- Package ivn_pkg holds:
  - FSM state encoding (RUN/SAVE/LOAD).
  - Child-index functions xor_child(i)=2i+1 and r_child(i)=2i+2.
  - The NPE-from-LEVELS function.
- One sub-module, ivn_pair_pe: {held, have} register, context load/save ports, combinational pair outputs.
- The top generates NPE instances and the context store.

Test Plan (LEVELS=2):
- Lane 0: bits 0,1 -> cycle after the second accept: vn_mask=3'b001, vn_bits[0]=0, vn_lane=0.
- Lane 0: bits 1,1,0,0 -> no output from PE0. Cycle after the 4th accept: vn_mask=3'b100, vn_bits[2]=1.
- Lane 0 bit 1 accepted, then lane 1 bit 0 offered:
  - in_ready=0 and busy=1 for 2 cycles, then the bit is accepted.
  - Lane 1 bit 1 -> output 0, mask 3'b001, vn_lane=1.
- Back to lane 0 bit 0 -> 2 stall cycles, then output 1, mask 3'b001, vn_lane=0 (held bit restored).
- Lane 0 bit 1, lane_flush pulse, bits 1,0 -> the flush cycle accepts nothing. The first 1 is discarded; output 1 from pair (1,0).
- Reset asserted during SAVE -> next cycle busy=0, cur_lane=0, all lanes empty. With IVN_STATS_EN: stat_count=0 for every stat_lane.

Source files
------------

// File: rtl/ivn_pkg.sv
// ivn_pkg: FSM encoding and tree-index helpers shared by the ivn_lane_extractor slice.
package ivn_pkg;
  typedef enum logic [1:0] {RUN, SAVE, LOAD} state_t;
  function automatic int npe(input int levels);
    return (1 << levels) - 1;
  endfunction
  function automatic int xor_child(input int i);
    return 2 * i + 1;
  endfunction
  function automatic int r_child(input int i);
    return 2 * i + 2;
  endfunction
endpackage

// File: rtl/ivn_pair_pe.sv
// ivn_pair_pe: one von Neumann pairing element with {held, have} state and context load/save.
module ivn_pair_pe (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev,
  input  logic       ev_bit,
  input  logic       clr,
  input  logic       load,
  input  logic [1:0] load_ctx,
  output logic [1:0] ctx,
  output logic       mask,
  output logic       out_bit,
  output logic       x_ev,
  output logic       x_bit,
  output logic       r_ev,
  output logic       r_bit
);
  logic held, have, pair;
  always_ff @(posedge clk)
    if (reset || clr) {held, have} <= 2'b00;
    else if (load) {held, have} <= load_ctx;
    else if (ev) {held, have} <= have ? {held, 1'b0} : {ev_bit, 1'b1};
  assign ctx = {held, have};
  assign pair = ev && have;
  assign mask = pair && held != ev_bit;
  assign out_bit = held;
  assign x_ev = pair;
  assign x_bit = held ^ ev_bit;
  assign r_ev = pair && held == ev_bit;
  assign r_bit = held;
endmodule

// File: rtl/ivn_lane_extractor.sv
// ivn_lane_extractor: multi-lane iterated von Neumann extractor with per-lane context switching.
// Define IVN_STATS_EN to add per-lane saturating extracted-bit counters (stat_lane/stat_count).
module ivn_lane_extractor import ivn_pkg::*; #(
  parameter int LEVELS = 3,
  parameter int LANES = 16,
  parameter int LANE_W = 4,
  localparam int NPE = npe(LEVELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic [LANE_W-1:0] in_lane,
  input  logic              lane_flush,
  output logic [NPE-1:0]    vn_bits,
  output logic [NPE-1:0]    vn_mask,
  output logic [LANE_W-1:0] vn_lane,
  output logic              busy
`ifdef IVN_STATS_EN
  ,
  input  logic [LANE_W-1:0] stat_lane,
  output logic [15:0]       stat_count
`endif
);
  state_t state, state_n;
  logic [LANE_W-1:0] cur_lane;
  logic [2*NPE-1:0] ctx [LANES];
  logic [2*NPE-1:0] pe_ctx, ld_ctx;
  logic [NPE-1:0] mask, bits;
  logic run, flush, mismatch;
  assign run = state == RUN;
  assign flush = run && lane_flush;
  assign mismatch = in_valid && in_lane != cur_lane;
  assign in_ready = run && in_valid && !mismatch && !lane_flush;
  assign busy = !run;
  assign ld_ctx = int'(in_lane) < LANES ? ctx[in_lane] : '0;
  // A flush holds RUN for its cycle, so a pending lane change starts one cycle later.
  always_comb begin
    state_n = RUN;
    state_n = state == SAVE ? LOAD : state == LOAD ? RUN : (!lane_flush && mismatch) ? SAVE : RUN;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      cur_lane <= '0;
    end else begin
      state <= state_n;
      if (state == LOAD) cur_lane <= in_lane;
    end
  always_ff @(posedge clk)
    if (reset) for (int l = 0; l < LANES; l++) ctx[l] <= '0;
    else if (state == SAVE) ctx[cur_lane] <= pe_ctx;
  for (genvar i = 0; i < NPE; i++) begin : g
    logic ev, ev_bit, m, ob, xe, xb, re, rb;
    if (i == 0) begin : root
      assign ev = in_ready;
      assign ev_bit = in_bit;
    end else if (xor_child((i - 1) / 2) == i) begin : xc
      assign ev = g[(i-1)/2].xe;
      assign ev_bit = g[(i-1)/2].xb;
    end else begin : rc
      assign ev = g[(i-1)/2].re;
      assign ev_bit = g[(i-1)/2].rb;
    end
    if (r_child(i) >= NPE) begin : leaf
      logic unused_out;
      assign unused_out = ^{xe, xb, re, rb};
    end
    ivn_pair_pe pe (
      .clk(clk), .reset(reset), .ev(ev), .ev_bit(ev_bit), .clr(flush), .load(state == LOAD),
      .load_ctx(ld_ctx[2*i+:2]), .ctx(pe_ctx[2*i+:2]), .mask(m), .out_bit(ob),
      .x_ev(xe), .x_bit(xb), .r_ev(re), .r_bit(rb)
    );
    assign mask[i] = m;
    assign bits[i] = m & ob;
  end
  always_ff @(posedge clk)
    if (reset) begin
      vn_bits <= '0;
      vn_mask <= '0;
      vn_lane <= '0;
    end else begin
      vn_bits <= bits;
      vn_mask <= mask;
      vn_lane <= cur_lane;
    end
`ifdef IVN_STATS_EN
  logic [15:0] cnt [LANES];
  logic [16:0] sum;
  assign sum = {1'b0, cnt[vn_lane]} + 17'($countones(vn_mask));
  always_ff @(posedge clk)
    if (reset) for (int l = 0; l < LANES; l++) cnt[l] <= '0;
    else begin
      if (vn_mask != '0) cnt[vn_lane] <= sum[16] ? 16'hFFFF : sum[15:0];
      if (flush) cnt[cur_lane] <= '0;
    end
  assign stat_count = cnt[stat_lane];
`endif
endmodule

// File: tb/tb_ivn_lane_extractor.sv
// tb_ivn_lane_extractor: scoreboard bench for ivn_lane_extractor at LEVELS=2.
module tb_ivn_lane_extractor;
  localparam int LEVELS = 2, LANES = 16, LANE_W = 4, NPE = 3;
  logic clk = 0, reset = 1, in_valid = 0, in_bit = 0, lane_flush = 0;
  logic [LANE_W-1:0] in_lane = '0;
  logic in_ready, busy;
  logic [NPE-1:0] vn_bits, vn_mask;
  logic [LANE_W-1:0] vn_lane;
`ifdef IVN_STATS_EN
  logic [LANE_W-1:0] stat_lane = '0;
  logic [15:0] stat_count;
`endif
  typedef struct packed {
    logic [NPE-1:0] mask;
    logic [NPE-1:0] bits;
    logic [LANE_W-1:0] lane;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ivn_lane_extractor #(.LEVELS(LEVELS), .LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .in_lane(in_lane), .lane_flush(lane_flush), .vn_bits(vn_bits), .vn_mask(vn_mask),
    .vn_lane(vn_lane), .busy(busy)
`ifdef IVN_STATS_EN
    , .stat_lane(stat_lane), .stat_count(stat_count)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && vn_mask != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got mask %b bits %b lane %0d expected none", vn_mask, vn_bits, vn_lane);
      end else begin
        e = sb.pop_front();
        chk("out_mask", int'(vn_mask), int'(e.mask));
        chk("out_bits", int'(vn_bits), int'(e.bits));
        chk("out_lane", int'(vn_lane), int'(e.lane));
      end
    end

  task automatic expect_out(input logic [NPE-1:0] m, input logic [NPE-1:0] b, input int lane);
    sb.push_back('{mask: m, bits: b, lane: LANE_W'(lane)});
  endtask

  task automatic send(input int lane, input logic b, input int exp_busy);
    int busy_n = 0;
    bit done = 0;
    in_valid = 1;
    in_lane = LANE_W'(lane);
    in_bit = b;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (busy) busy_n++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("accept", int'(done), 1);
    chk("busy_cycles", busy_n, exp_busy);
  endtask

  task automatic flush(input int lane, input logic b);
    lane_flush = 1;
    in_valid = 1;
    in_lane = LANE_W'(lane);
    in_bit = b;
    @(negedge clk);
    chk("flush_ready", int'(in_ready), 0);
    chk("flush_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    lane_flush = 0;
    in_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_mask", int'(vn_mask), 0);
    chk("rst_bits", int'(vn_bits), 0);
    chk("rst_lane", int'(vn_lane), 0);
    chk("rst_busy", int'(busy), 0);
    in_valid = 1;
    #1 chk("rst_ready", int'(in_ready), 1);
    in_valid = 0;
    // pair (0,1) on lane 0
    expect_out(3'b001, 3'b000, 0);
    send(0, 0, 0);
    send(0, 1, 0);
    @(posedge clk);
    #1;
`ifdef IVN_STATS_EN
    stat_lane = '0;
    #1 chk("stat_after_pair", int'(stat_count), 1);
`endif
    flush(0, 1);
`ifdef IVN_STATS_EN
    #1 chk("stat_after_flush", int'(stat_count), 0);
`endif
    // 1,1,0,0 -> only r child PE2 sees the pair (1,0)
    send(0, 1, 0);
    send(0, 1, 0);
    send(0, 0, 0);
    expect_out(3'b100, 3'b100, 0);
    send(0, 0, 0);
    // lane switch keeps held bits per lane
    send(0, 1, 0);
    send(1, 0, 2);
    expect_out(3'b001, 3'b000, 1);
    send(1, 1, 0);
    expect_out(3'b001, 3'b001, 0);
    send(0, 0, 2);
    // flush discards the held 1
    send(0, 1, 0);
    flush(0, 1);
    send(0, 1, 0);
    expect_out(3'b001, 3'b001, 0);
    send(0, 0, 0);
    // flush together with a lane change: no switch in the flush cycle
    lane_flush = 1;
    in_valid = 1;
    in_lane = 4'd2;
    in_bit = 1;
    @(negedge clk);
    chk("flushmis_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 lane_flush = 0;
    @(negedge clk);
    chk("flush_wins_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    send(2, 1, 2);
    // reset in the middle of a switch
    send(0, 1, 2);
    in_valid = 1;
    in_lane = 4'd5;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("save_busy", int'(busy), 1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    in_valid = 0;
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_mask", int'(vn_mask), 0);
    chk("rst2_lane", int'(vn_lane), 0);
    in_valid = 1;
    in_lane = '0;
    #1 chk("rst2_ready", int'(in_ready), 1);
    in_valid = 0;
`ifdef IVN_STATS_EN
    for (int l = 0; l < LANES; l++) begin
      stat_lane = LANE_W'(l);
      #1 chk("rst2_stat", int'(stat_count), 0);
    end
`endif
    expect_out(3'b001, 3'b000, 0);
    send(0, 0, 0);
    send(0, 1, 0);
    send(1, 1, 2);
    send(1, 1, 0);
    repeat (4) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
